usart_tx_bamse: RTL
===================

Name: usart_tx_bamse

Overview:
- Bus-attached UART transmitter for the BAMSE peripheral bus; the transmit counterpart of the USART receive block.
- A bus write to ADDR loads one byte. The block serialises it as 8N1, LSB first, and raises a level interrupt when transmission is done.
- Contains its own bit-timing counter and frame FSM; it does not depend on the RX module.

Parameters:
- ADDR, 8'b0000_0000, bus address the block responds to.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- port_in  input  8  bus write data.
- address  input  8  bus address.
- wen  input  1  bus write enable.
- clk_per_bit  input  12  clk cycles per bit (clk_frequency / bit_rate); connect to CONFIG_UART_TX register.
- tx  output  1  serial line; idles high.
- ready  output  1  high when a write to ADDR will be accepted.
- int_tx  output  1  transmit-done interrupt, level.

Behaviour:
- Write accept: address==ADDR && wen && ready, sampled at a posedge. Writes when ready=0 are silently dropped.
- Reset (any cycle, including mid-frame):
  - state=IDLE, tx=1, ready=1, int_tx=0;
  - counters cleared; holding register (if compiled in) emptied;
  - tx is 1 at the first edge with rst=1.
- FSM states and transitions:
  - IDLE: tx=1. On accept → START.
  - START: tx=0 for one bit period → DATA.
  - DATA: tx=shift[0] per bit; 8 bits LSB first, 3-bit index 0..7 → STOP.
  - STOP: tx=1 for one bit period → IDLE, or → START if a byte is pending.
- Bit period:
  - clk_per_bit is latched at the accept edge and held for the whole frame.
  - Effective period = max(latched value, 1) cycles; a value of 0 is treated as 1.
  - Bit counter is 12-bit, counts 0..period-1, then wraps.
- Timing: accept at edge N → tx=0 from edge N+1. Frame length is exactly 10*period cycles. STOP ends at edge N+1+10*period.
- ready: equals (state==IDLE) without the optional feature; deasserts at the accept edge.
- int_tx:
  - set to 1 at the edge where the FSM enters IDLE from STOP;
  - cleared at the edge of an accepted write;
  - if set and clear coincide, clear wins;
  - stays 1 while idle until the next accepted write.
- port_in is captured into the shift register at accept; later changes have no effect.

Optional Feature:
- Macro: USART_TX_HOLD_EN.
- Defined: adds a one-byte holding register.
  - ready = holding register empty.
  - An accept while busy fills the holding register.
  - At STOP end, a held byte loads into shift (and clk_per_bit is re-latched); FSM → START with no idle gap.
  - int_tx is set only on entering IDLE with the holding register empty.
  - An accept in the last STOP cycle with hold empty goes to hold, then loads; int_tx stays 0.
- Undefined: no holding register; behaviour exactly as above.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - DATA_BITS=8;
  - CPB_W=12;
  - idle line level constant.
- One natural sub-module: uart_tx_core. It holds the FSM, bit counter and shift register, with handshake i_start/i_byte/o_busy/o_done.
- The top level holds the address decode, holding register and int_tx logic.

Test Plan:
- clk_per_bit=4, write 0xA5 at edge N → tx=0 for edges N+1..N+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1. int_tx=1 and ready=1 at edge N+41.
- Write 0x3C while busy (no hold) → dropped; tx pattern of the first frame unchanged; only one int_tx rise.
- Assert rst at cycle 15 of a frame → tx=1, ready=1, int_tx=0 from that edge. A new write of 0xFF then transmits a clean frame.
- clk_per_bit=0, write 0x01 → period is 1 cycle, frame is 10 cycles, tx=0,1,0,0,0,0,0,0,0,1.
- int_tx=1, then write 0x55 → int_tx=0 at the accept edge; a write to ADDR+1 leaves int_tx=1 and tx idle.
- USART_TX_HOLD_EN, clk_per_bit=2, write 0x11 then 0x22 one cycle later → two back-to-back frames (40 cycles, no gap). int_tx rises once, at edge N+41.

Source files
------------

// File: rtl/usart_tx_bamse_pkg.sv
// +-----------------------------------------------------------------------+
// | usart_tx_bamse_pkg : shared types and constants for the UART TX block |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package usart_tx_bamse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam int   CPB_W      = 12;
  localparam logic IDLE_LEVEL = 1'b1;

  // Last count value of a bit period; a zero period is treated as one cycle.
  function automatic logic [CPB_W-1:0] bit_last(input logic [CPB_W-1:0] cpb);
    return (cpb == '0) ? '0 : (cpb - CPB_W'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/usart_tx_bamse_uart_tx_core.sv
// +-----------------------------------------------------------------------+
// | uart_tx_core : 8N1 frame FSM, bit-timing counter and shift register   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_tx_core
  import usart_tx_bamse_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_byte,
  input  logic [CPB_W-1:0]     i_cpb,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [CPB_W-1:0]     cnt_q;
  logic [CPB_W-1:0]     last_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           idx_q;
  logic                 tx_q;

  logic w_bit_end;
  logic w_load;

  assign w_bit_end = (cnt_q == last_q);
  assign o_done    = (state_q == ST_STOP) && w_bit_end;
  // A new frame may start from idle or directly from the last stop cycle.
  assign w_load    = i_start && ((state_q == ST_IDLE) || o_done);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_tx      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= IDLE_LEVEL;
      cnt_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else if (w_load) begin
      state_q <= ST_START;
      tx_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= bit_last(i_cpb);
      shift_q <= i_byte;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= IDLE_LEVEL;
        end
        ST_START: begin
          if (w_bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_STOP;
              tx_q    <= IDLE_LEVEL;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/usart_tx_bamse.sv
// +-----------------------------------------------------------------------+
// | usart_tx_bamse : BAMSE bus UART transmitter, 8N1, level done irq      |
// | Rev 1.0   optional holding register: `define USART_TX_HOLD_EN        |
// +-----------------------------------------------------------------------+
`default_nettype none

module usart_tx_bamse
  import usart_tx_bamse_pkg::*;
#(
  parameter logic [7:0] ADDR = 8'b0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  port_in,
  input  logic [7:0]  address,
  input  logic        wen,
  input  logic [11:0] clk_per_bit,
  output logic        tx,
  output logic        ready,
  output logic        int_tx
);

  logic                 start_q;
  logic [DATA_BITS-1:0] byte_q;
  logic [CPB_W-1:0]     cpb_q;
  logic                 int_tx_q;
  logic                 int_tx_d;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_core_start;
  logic [DATA_BITS-1:0] w_core_byte;
  logic [CPB_W-1:0]     w_core_cpb;
  logic                 w_direct;
  logic                 w_int_set;

  assign w_accept = (address == ADDR) && wen && ready;

`ifdef USART_TX_HOLD_EN
  logic                 hold_full_q;
  logic [DATA_BITS-1:0] hold_byte_q;
  logic                 w_hold_go;

  assign ready        = !hold_full_q;
  assign w_direct     = w_accept && !w_busy && !start_q;
  // Held byte goes out at the end of a stop bit (no gap) or as soon as the core is idle.
  assign w_hold_go    = hold_full_q && !start_q && (!w_busy || w_done);
  assign w_core_start = start_q || w_hold_go;
  assign w_core_byte  = start_q ? byte_q : hold_byte_q;
  assign w_core_cpb   = start_q ? cpb_q : clk_per_bit;
  assign w_int_set    = w_done && !hold_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
    end else if (w_hold_go) begin
      hold_full_q <= 1'b0;
    end else if (w_accept && !w_direct) begin
      hold_full_q <= 1'b1;
      hold_byte_q <= port_in;
    end
  end
`else
  assign ready        = !w_busy && !start_q;
  assign w_direct     = w_accept;
  assign w_core_start = start_q;
  assign w_core_byte  = byte_q;
  assign w_core_cpb   = cpb_q;
  assign w_int_set    = w_done;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      byte_q  <= '0;
      cpb_q   <= '0;
    end else begin
      start_q <= w_direct;
      if (w_direct) begin
        byte_q <= port_in;
        cpb_q  <= clk_per_bit;
      end
    end
  end

  // Clearing by an accepted write takes priority over the done event.
  always_comb begin
    int_tx_d = int_tx_q;
    if (w_accept) begin
      int_tx_d = 1'b0;
    end else if (w_int_set) begin
      int_tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_tx_q <= 1'b0;
    end else begin
      int_tx_q <= int_tx_d;
    end
  end

  assign int_tx = int_tx_q;

  uart_tx_core u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_core_start),
    .i_byte  (w_core_byte),
    .i_cpb   (w_core_cpb),
    .o_tx    (tx),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

endmodule

`default_nettype wire
